// File: rtl/led_pwm_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_ctrl_pkg
//   Shared definitions for the multi-channel LED PWM driver: mode encodings,
//   breathe direction, common widths and a counter-width helper.
// -----------------------------------------------------------------------------
package led_pwm_ctrl_pkg;

    localparam int MODE_W   = 3;   // width of a channel mode field
    localparam int CH_IDX_W = 5;   // width of the write/readback channel index

    // Channel modes; encodings 5..7 are reserved and drive the LED off.
    typedef enum logic [MODE_W-1:0] {
        LED_OFF     = 3'd0,
        LED_ON      = 3'd1,
        LED_PWM     = 3'd2,
        LED_BLINK   = 3'd3,
        LED_BREATHE = 3'd4
    } led_mode_e;

    typedef enum logic {
        BREATHE_UP   = 1'b0,
        BREATHE_DOWN = 1'b1
    } breathe_dir_e;

    // Width of a counter that has to hold 0..n-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : led_pwm_ctrl_pkg

// File: rtl/led_pwm_timebase.sv
// -----------------------------------------------------------------------------
// led_pwm_timebase
//   Common timebase shared by every LED channel: prescaler, PWM counter,
//   period wrap / period_start, blink phase and breathe level.
//
//   Ports
//     clk           in   system clock
//     rst           in   async reset, active-high
//     pwm_cnt       out  PWM counter, advances once per prescaler tick
//     wrap          out  combinational, high on the last clk of a PWM period
//     period_start  out  registered wrap (one-cycle pulse, 1 clk after wrap)
//     blink_phase   out  blink on/off half-cycle
//     breathe_lvl   out  triangle brightness level 0..max..0
// -----------------------------------------------------------------------------
module led_pwm_timebase
    import led_pwm_ctrl_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 6104,
    parameter int BREATHE_STEP  = 24
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                wrap,
    output logic                period_start,
    output logic                blink_phase,
    output logic [PWM_BITS-1:0] breathe_lvl
);

    localparam int PRESC_W = cnt_width(PRESCALE);
    localparam int BLINK_W = cnt_width(BLINK_PERIODS);
    localparam int STEP_W  = cnt_width(BREATHE_STEP);

    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_PERIODS - 1);
    localparam logic [STEP_W-1:0]   STEP_LAST  = STEP_W'(BREATHE_STEP - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [PWM_BITS-1:0] LVL_TOP    = CNT_MAX - PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LVL_ONE    = PWM_BITS'(1);

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [BLINK_W-1:0] blink_cnt;
    logic [STEP_W-1:0]  breathe_cnt;
    logic               breathe_step;
    breathe_dir_e       breathe_dir;

    assign tick         = (presc == PRESC_LAST);
    assign wrap         = tick && (pwm_cnt == CNT_MAX);
    assign breathe_step = wrap && (breathe_cnt == STEP_LAST);

    // Prescaler, PWM counter and the registered period boundary pulse.
    // NOTE: state registers use non-blocking assignments so every register in
    // the design samples the pre-edge values of the others; that is what makes
    // a write landing on the wrap edge reach the active set one period later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc        <= '0;
            pwm_cnt      <= '0;
            period_start <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            period_start <= wrap;
        end
    end

    // Blink: count whole PWM periods, flip the phase on every rollover.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Breathe: step the level once every BREATHE_STEP periods. The direction
    // flips on the step that lands on an endpoint, so neither max nor 0 is
    // held for two steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            breathe_cnt <= '0;
            breathe_lvl <= '0;
            breathe_dir <= BREATHE_UP;
        end else begin
            if (wrap) begin
                breathe_cnt <= (breathe_cnt == STEP_LAST) ? '0 : breathe_cnt + 1'b1;
            end
            if (breathe_step) begin
                if (breathe_dir == BREATHE_UP) begin
                    breathe_lvl <= breathe_lvl + 1'b1;
                    if (breathe_lvl == LVL_TOP) begin
                        breathe_dir <= BREATHE_DOWN;
                    end
                end else begin
                    breathe_lvl <= breathe_lvl - 1'b1;
                    if (breathe_lvl == LVL_ONE) begin
                        breathe_dir <= BREATHE_UP;
                    end
                end
            end
        end
    end

endmodule : led_pwm_timebase

// File: rtl/led_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// led_pwm_ctrl
//   Multi-channel LED driver. Each channel has a shadow {mode, duty} written
//   over a one-cycle strobe and an active copy that loads from the shadow at
//   every PWM period boundary, so brightness changes never glitch mid-period.
//   Modes: OFF, ON, PWM, BLINK, BREATHE (5..7 reserved, LED off).
//   force_on drives every LED solid on regardless of mode.
//
//   Ports
//     clk           in   system clock (100 MHz)
//     rst           in   async reset, active-high
//     wr_en         in   write strobe, one cycle
//     wr_ch         in   channel to write; indices >= NUM_CH are ignored
//     wr_mode       in   mode to write
//     wr_duty       in   duty to write
//     rd_ch         in   channel to read back; indices >= NUM_CH read 0
//     rd_mode       out  active mode of rd_ch, registered
//     rd_duty       out  active duty of rd_ch, registered
//     force_on      in   all LEDs on while high
//     period_start  out  one-cycle pulse at each PWM period boundary
//     led           out  LED drive, registered, active-high
// -----------------------------------------------------------------------------
module led_pwm_ctrl
    import led_pwm_ctrl_pkg::*;
#(
    parameter int NUM_CH        = 16,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 16,
    parameter int BLINK_PERIODS = 6104,
    parameter int BREATHE_STEP  = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [MODE_W-1:0]   wr_mode,
    input  logic [PWM_BITS-1:0] wr_duty,
    input  logic [CH_IDX_W-1:0] rd_ch,
    output logic [MODE_W-1:0]   rd_mode,
    output logic [PWM_BITS-1:0] rd_duty,
    input  logic                force_on,
    output logic                period_start,
    output logic [NUM_CH-1:0]   led
);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                wrap;
    logic                blink_phase;
    logic [PWM_BITS-1:0] breathe_lvl;

    // Modes are kept as raw 3-bit fields so reserved encodings read back as
    // written.
    logic [MODE_W-1:0]   shadow_mode [NUM_CH];
    logic [PWM_BITS-1:0] shadow_duty [NUM_CH];
    logic [MODE_W-1:0]   active_mode [NUM_CH];
    logic [PWM_BITS-1:0] active_duty [NUM_CH];

    logic [NUM_CH-1:0]   led_nxt;
    logic [MODE_W-1:0]   rd_mode_nxt;
    logic [PWM_BITS-1:0] rd_duty_nxt;

    led_pwm_timebase #(
        .PWM_BITS      (PWM_BITS),
        .PRESCALE      (PRESCALE),
        .BLINK_PERIODS (BLINK_PERIODS),
        .BREATHE_STEP  (BREATHE_STEP)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .pwm_cnt      (pwm_cnt),
        .wrap         (wrap),
        .period_start (period_start),
        .blink_phase  (blink_phase),
        .breathe_lvl  (breathe_lvl)
    );

    // Shadow writes and boundary apply. Comparing wr_ch against each channel
    // number (rather than indexing) drops out-of-range writes for free.
    // NOTE: these arrays are flops, not RAM: every channel must come out of
    // reset OFF, so each entry is reset explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_mode[i] <= '0;
                shadow_duty[i] <= '0;
                active_mode[i] <= '0;
                active_duty[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap) begin
                    active_mode[i] <= shadow_mode[i];
                    active_duty[i] <= shadow_duty[i];
                end
                if (wr_en && (wr_ch == CH_IDX_W'(i))) begin
                    shadow_mode[i] <= wr_mode;
                    shadow_duty[i] <= wr_duty;
                end
            end
        end
    end

    // Per-channel compare against the shared timebase.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [PWM_BITS-1:0] breathe_duty;
        logic                on_nxt;

        // BREATHE follows the triangle level but never exceeds the set duty.
        assign breathe_duty = (breathe_lvl < active_duty[g]) ? breathe_lvl : active_duty[g];

        // NOTE: on_nxt gets its default before the case so every path assigns
        // it and no latch is inferred.
        always_comb begin
            on_nxt = 1'b0;
            case (active_mode[g])
                LED_ON:      on_nxt = 1'b1;
                LED_PWM:     on_nxt = (pwm_cnt < active_duty[g]);
                LED_BLINK:   on_nxt = blink_phase && (pwm_cnt < active_duty[g]);
                LED_BREATHE: on_nxt = (pwm_cnt < breathe_duty);
                default:     on_nxt = 1'b0;
            endcase
            if (force_on) begin
                on_nxt = 1'b1;
            end
        end

        assign led_nxt[g] = on_nxt;
    end

    // Readback mux over the active set; unmatched indices fall through to 0.
    always_comb begin
        rd_mode_nxt = '0;
        rd_duty_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_ch == CH_IDX_W'(i)) begin
                rd_mode_nxt = active_mode[i];
                rd_duty_nxt = active_duty[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led     <= '0;
            rd_mode <= '0;
            rd_duty <= '0;
        end else begin
            led     <= led_nxt;
            rd_mode <= rd_mode_nxt;
            rd_duty <= rd_duty_nxt;
        end
    end

endmodule : led_pwm_ctrl
